// File: rtl/vmul_pkg.sv
// Shared types and widths for the shared Vedic multiplier controller.
package vmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } vmul_state_e;

    localparam int OP_W = 8;
    localparam int P_W  = 16;

endpackage

// File: rtl/i8bit_mul.sv
// Unsigned 8x8 Vedic (Urdhva-Tiryagbhyam) multiplier: column k sums the crosswise products a[i]&b[k-i].
module i8bit_mul
    import vmul_pkg::*;
(
    output logic [P_W-1:0]  s,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b
);

    logic [P_W-1:0] term [2*OP_W-1];

    generate
        for (genvar gk = 0; gk < 2*OP_W-1; gk++) begin : g_col
            logic [OP_W-1:0] diag;
            for (genvar gi = 0; gi < OP_W; gi++) begin : g_bit
                if (gk - gi >= 0 && gk - gi < OP_W) begin : g_on
                    assign diag[gi] = a[gi] & b[gk-gi];
                end else begin : g_off
                    assign diag[gi] = 1'b0;
                end
            end
            assign term[gk] = P_W'($countones(diag)) << gk;
        end
    endgenerate

    always_comb begin
        s = '0;
        for (int k = 0; k < 2*OP_W-1; k++) begin
            s = s + term[k[3:0]];
        end
    end

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: grants the first set request at or above ptr, wrapping.
module rr_arb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [W:0]   cand;
    logic [W-1:0] sel;
    logic         found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        sel     = '0;
        for (int off = 0; off < N; off++) begin
            // One extra bit so ptr+off never overflows before the modulo fold.
            cand = {1'b0, ptr} + (W+1)'(off);
            if (cand >= (W+1)'(N)) begin
                cand = cand - (W+1)'(N);
            end
            sel = cand[W-1:0];
            if (!found && req[sel]) begin
                found        = 1'b1;
                gnt[sel]     = 1'b1;
                gnt_idx      = sel;
            end
        end
    end

endmodule

// File: rtl/vmul_share_ctrl.sv
// Shares one i8bit_mul among N_REQ requesters: round-robin accept, registered operands, tagged response.
module vmul_share_ctrl
    import vmul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [OP_W*N_REQ-1:0] req_a,
    input  logic [OP_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [P_W-1:0]        rsp_p
);

    vmul_state_e     state_reg;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  id_reg;
    logic [OP_W-1:0] op_a_reg;
    logic [OP_W-1:0] op_b_reg;
    logic [P_W-1:0]  rsp_p_reg;
    logic [IDW-1:0]  rsp_id_reg;

    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   ptr_next;
    logic [P_W-1:0]   mul_s;
    logic [OP_W-1:0]  a_arr [N_REQ];
    logic [OP_W-1:0]  b_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[OP_W*gi +: OP_W];
            assign b_arr[gi] = req_b[OP_W*gi +: OP_W];
        end
    endgenerate

    rr_arb #(.N(N_REQ), .W(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Multiplier sees only the registered operands, never the request bus.
    i8bit_mul u_mul (
        .s (mul_s),
        .a (op_a_reg),
        .b (op_b_reg)
    );

    assign req_ready = (state_reg == IDLE && !rst) ? gnt : '0;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_p     = rsp_p_reg;
    assign rsp_id    = rsp_id_reg;
    assign ptr_next  = (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            id_reg     <= '0;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            rsp_p_reg  <= '0;
            rsp_id_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_ready) begin
                        op_a_reg  <= a_arr[gnt_idx];
                        op_b_reg  <= b_arr[gnt_idx];
                        id_reg    <= gnt_idx;
                        ptr_reg   <= ptr_next;
                        state_reg <= MUL;
                    end
                end
                MUL: begin
                    rsp_p_reg  <= mul_s;
                    rsp_id_reg <= id_reg;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vmul_share_ctrl.sv
// Directed bench for vmul_share_ctrl: vector table of single requests plus contention, backpressure and reset sequences.
module tb_vmul_share_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_p;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [8];

    vmul_share_ctrl #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
        req_a[8*idx +: 8] = a;
        req_b[8*idx +: 8] = b;
    endtask

    // Waits (bounded) for a grant; a timeout shows up as a grant mismatch.
    task automatic accept_wait(input logic [3:0] exp_gnt, input string name);
        int n = 0;
        while (req_ready == 4'b0 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, 32'(req_ready), 32'(exp_gnt));
    endtask

    // Called in the accept cycle; scrambles operands afterwards to show they were captured.
    task automatic finish_rsp(input logic [1:0] exp_id, input logic [15:0] exp_p, input string name);
        @(negedge clk);
        req_valid = 4'b0;
        req_a = $urandom;
        req_b = $urandom;
        #1;
        chk({name, "_mul_valid"}, 32'(rsp_valid), 0);
        chk({name, "_mul_ready"}, 32'(req_ready), 0);
        @(negedge clk); #1;
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 1);
        chk({name, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
        chk({name, "_rsp_p"}, 32'(rsp_p), 32'(exp_p));
    endtask

    initial begin
        logic [3:0]  drop;
        logic [15:0] cont_p [4];
        int kg, kr, last;

        vecs[0] = '{1, 8'd12,  8'd5,   16'd60};
        vecs[1] = '{3, 8'd255, 8'd255, 16'd65025};
        vecs[2] = '{0, 8'd0,   8'd200, 16'd0};
        vecs[3] = '{2, 8'd170, 8'd85,  16'd14450};
        vecs[4] = '{1, 8'd1,   8'd255, 16'd255};
        vecs[5] = '{0, 8'd16,  8'd16,  16'd256};
        vecs[6] = '{2, 8'd240, 8'd15,  16'd3600};
        vecs[7] = '{3, 8'd255, 8'd1,   16'd255};
        cont_p[0] = 16'd65025;
        cont_p[1] = 16'd14450;
        cont_p[2] = 16'd3600;
        cont_p[3] = 16'd60;

        rst = 1'b1;
        req_valid = 4'b0;
        req_a = 32'b0;
        req_b = 32'b0;
        rsp_ready = 1'b1;

        // Reset held for two edges with random requests
        repeat (2) begin
            @(negedge clk);
            req_valid = 4'($urandom) | 4'b0001;
            #1;
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_p", 32'(rsp_p), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
        end
        rst = 1'b0;
        req_valid = 4'b1011;
        set_op(0, 8'd7, 8'd9);
        set_op(1, 8'd3, 8'd3);
        set_op(3, 8'd4, 8'd4);
        #1;
        accept_wait(4'b0001, "first_grant");
        finish_rsp(2'd0, 16'd63, "first");

        // Table of single requests
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_a = $urandom;
            req_b = $urandom;
            set_op(vecs[i].idx, vecs[i].a, vecs[i].b);
            req_valid = 4'(1 << vecs[i].idx);
            rsp_ready = 1'b1;
            #1;
            accept_wait(4'(1 << vecs[i].idx), $sformatf("vec%0d_grant", i));
            finish_rsp(2'(vecs[i].idx), vecs[i].p, $sformatf("vec%0d", i));
        end

        // Full contention; pointer is back at 0 after the last vector (requester 3)
        @(negedge clk);
        set_op(0, 8'd255, 8'd255);
        set_op(1, 8'd170, 8'd85);
        set_op(2, 8'd240, 8'd15);
        set_op(3, 8'd12, 8'd5);
        req_valid = 4'hF;
        drop = 4'b0;
        kg = 0; kr = 0; last = 0;
        for (int c = 0; c < 40 && kr < 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                req_valid = req_valid & ~drop;
                drop = 4'b0;
            end
            #1;
            if (rsp_valid) begin
                chk($sformatf("cont_rsp%0d_id", kr), 32'(rsp_id), 32'(kr));
                chk($sformatf("cont_rsp%0d_p", kr), 32'(rsp_p), 32'(cont_p[kr]));
                kr++;
            end
            if (req_ready != 4'b0) begin
                chk($sformatf("cont_gnt%0d", kg), 32'(req_ready), (kg < 4) ? 32'(1 << kg) : 0);
                if (kg > 0) chk($sformatf("cont_space%0d", kg), 32'(c - last), 3);
                last = c;
                drop = req_ready;
                kg++;
            end
        end
        chk("cont_rsp_count", 32'(kr), 4);

        // Fairness: 0 and 2 request continuously
        @(negedge clk);
        set_op(0, 8'd10, 8'd10);
        set_op(2, 8'd20, 8'd3);
        req_valid = 4'b0101;
        kg = 0;
        #1;
        for (int c = 0; c < 40 && kg < 6; c++) begin
            if (c > 0) begin
                @(negedge clk); #1;
            end
            if (req_ready != 4'b0) begin
                chk($sformatf("fair_gnt%0d", kg), 32'(req_ready), (kg % 2 == 1) ? 32'h4 : 32'h1);
                kg++;
            end
        end
        chk("fair_gnt_count", 32'(kg), 6);
        finish_rsp(2'd2, 16'd60, "fair_last");

        // Pointer now 3: search must wrap past 3 to reach requester 0
        @(negedge clk);
        set_op(0, 8'd3, 8'd4);
        set_op(1, 8'd9, 8'd9);
        req_valid = 4'b0011;
        #1;
        accept_wait(4'b0001, "wrap_grant");
        finish_rsp(2'd0, 16'd12, "wrap");

        // Backpressure: response held while another request waits
        @(negedge clk);
        set_op(2, 8'd171, 8'd205);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        accept_wait(4'b0100, "bp_grant");
        @(negedge clk);
        req_valid = 4'b0001;
        set_op(0, 8'd2, 8'd3);
        set_op(2, 8'd1, 8'd1);
        #1;
        chk("bp_mul_valid", 32'(rsp_valid), 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 1);
            chk($sformatf("bp%0d_p", c), 32'(rsp_p), 35055);
            chk($sformatf("bp%0d_id", c), 32'(rsp_id), 2);
            chk($sformatf("bp%0d_ready", c), 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_release_valid", 32'(rsp_valid), 0);
        chk("bp_release_grant", 32'(req_ready), 1);
        finish_rsp(2'd0, 16'd6, "bp_next");

        // Reset during MUL discards the in-flight 238x255
        @(negedge clk);
        set_op(1, 8'd238, 8'd255);
        req_valid = 4'b0010;
        #1;
        accept_wait(4'b0010, "rmid_grant");
        @(negedge clk);
        req_valid = 4'b0;
        #1;
        chk("rmid_mul_valid", 32'(rsp_valid), 0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rmid_valid", 32'(rsp_valid), 0);
        chk("rmid_p", 32'(rsp_p), 0);
        chk("rmid_ready", 32'(req_ready), 0);
        rst = 1'b0;
        set_op(0, 8'd9, 8'd9);
        set_op(2, 8'd5, 8'd5);
        req_valid = 4'b0101;
        #1;
        chk("rmid_ptr0_grant", 32'(req_ready), 1);
        finish_rsp(2'd0, 16'd81, "rmid_next");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
